// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-CPU: datapath widths, opcodes and
// the execute-stage state encoding.
package cpu_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_MUL = 3'd6,
        OP_NOT = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DW cycles
// after start, full 2*DW-bit product held until the next start.
module mul_iter
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            areset,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int CW = $clog2(DW + 1);

    logic [2*DW-1:0] mcand_q;
    logic [2*DW-1:0] prod_q;
    logic [DW-1:0]   mplr_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= {{DW{1'b0}}, a};
            prod_q  <= '0;
            mplr_q  <= b;
            cnt_q   <= CW'(DW);
        end else if (busy) begin
            if (mplr_q[0])
                prod_q <= prod_q + mcand_q;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    assign busy    = (cnt_q != '0);
    // asserted during the cycle whose edge performs the final iteration
    assign done    = (cnt_q == CW'(1));
    assign product = prod_q;

endmodule

// File: rtl/exec_stage.sv
// Execute/write-back stage: accepts one reg-reg instruction, computes it
// (single-cycle ALU or iterative multiply) and writes it back with flags.
//
//   state   | meaning
//   IDLE    | ready; read addresses follow rs1/rs2 inputs
//   MUL     | multiplier iterating on latched operands
//   WB      | one-cycle register-file write, flags update at its edge
module exec_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          areset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic [AW-1:0] raddr1,
    output logic [AW-1:0] raddr2,
    input  logic [DW-1:0] rout1,
    input  logic [DW-1:0] rout2,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          flag_z,
    output logic          flag_c
);

    state_t          state_q, state_d;
    op_t             op_q;
    logic [AW-1:0]   rd_q, rs1_q, rs2_q, waddr_q;
    logic [DW-1:0]   a_q, b_q, wdata_q;
    logic            flag_z_q, flag_c_q;
    logic            accept, mul_start, mul_busy, mul_done;
    logic [2*DW-1:0] mul_product;
    logic [DW:0]     alu_out;

    // returns {carry/borrow/overflow, result}
    function automatic logic [DW:0] alu(input op_t o, input logic [DW-1:0] x,
                                        input logic [DW-1:0] y,
                                        input logic [2*DW-1:0] p);
        logic [DW:0] r;
        r = '0;
        case (o)
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            OP_SUB:  r = {1'b0, x} - {1'b0, y};
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_XOR:  r = {1'b0, x ^ y};
            OP_MOV:  r = {1'b0, x};
            OP_MUL:  r = {|p[2*DW-1:DW], p[DW-1:0]};
            OP_NOT:  r = {1'b0, ~x};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign mul_start = accept && (op_t'(op) == OP_MUL);
    assign alu_out   = alu(op_q, a_q, b_q, mul_product);

    mul_iter u_mul (
        .clk     (clk),
        .areset  (areset),
        .start   (mul_start),
        .a       (rout1),
        .b       (rout2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_t'(op);
                rd_q  <= rd;
                rs1_q <= rs1;
                rs2_q <= rs2;
                a_q   <= rout1;
                b_q   <= rout2;
            end
            if (state_q == ST_WB) begin
                waddr_q  <= rd_q;
                wdata_q  <= alu_out[DW-1:0];
                flag_z_q <= (alu_out[DW-1:0] == '0);
                flag_c_q <= alu_out[DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (op_t'(op) == OP_MUL) ? ST_MUL : ST_WB;
            ST_MUL:  if (mul_done || !mul_busy) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign raddr1   = in_ready ? rs1 : rs1_q;
    assign raddr2   = in_ready ? rs2 : rs2_q;
    assign we       = (state_q == ST_WB);
    assign waddr    = we ? rd_q : waddr_q;
    assign wdata    = we ? alu_out[DW-1:0] : wdata_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage with an attached register file and a
// cycle-level behavioural model checked on every falling edge.
module tb_exec_stage;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rout1, rout2;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          flag_z, flag_c;

    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_val = '0;
    logic [DW-1:0] rf [8];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    exec_stage dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .raddr1(raddr1), .raddr2(raddr2), .rout1(rout1), .rout2(rout2),
        .we(we), .waddr(waddr), .wdata(wdata), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (we) begin
            rf[waddr] <= wdata;
        end else if (pre_en) begin
            rf[pre_addr] <= pre_val;
        end
    end
    assign rout1 = rf[raddr1];
    assign rout2 = rf[raddr2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    int mrf [8];
    bit pending = 0;
    int wb_cyc, exp_rd, exp_res, m_rs1, m_rs2;
    bit exp_c, m_z = 0, m_c = 0;
    int acc_cyc [$];
    int last_we_cyc = -1;
    int we_seen = 0;

    always @(negedge clk) begin
        bit ew;
        int x, y, full;
        if (we) we_seen++;
        if (areset) begin
            pending = 0; m_z = 0; m_c = 0;
            for (int i = 0; i < 8; i++) mrf[i] = 0;
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_we", int'(we), 0);
            chk("rst_flag_z", int'(flag_z), 0);
            chk("rst_flag_c", int'(flag_c), 0);
        end else begin
            ew = pending && (cyc == wb_cyc);
            chk("in_ready", int'(in_ready), int'(!pending));
            chk("we", int'(we), int'(ew));
            chk("flag_z", int'(flag_z), int'(m_z));
            chk("flag_c", int'(flag_c), int'(m_c));
            if (pending) begin
                chk("raddr1_hold", int'(raddr1), m_rs1);
                chk("raddr2_hold", int'(raddr2), m_rs2);
            end
            if (ew) begin
                chk("waddr", int'(waddr), exp_rd);
                chk("wdata", int'(wdata), exp_res);
                mrf[exp_rd] = exp_res;
                m_z = (exp_res == 0);
                m_c = exp_c;
                pending = 0;
                last_we_cyc = cyc;
            end else if (!pending && in_valid) begin
                x = mrf[rs1]; y = mrf[rs2];
                case (op)
                    3'd0: begin full = x + y;       exp_res = full % 256; exp_c = (full > 255); end
                    3'd1: begin exp_res = (x - y + 256) % 256;          exp_c = (x < y);      end
                    3'd2: begin exp_res = x & y;    exp_c = 0; end
                    3'd3: begin exp_res = x | y;    exp_c = 0; end
                    3'd4: begin exp_res = x ^ y;    exp_c = 0; end
                    3'd5: begin exp_res = x;        exp_c = 0; end
                    3'd6: begin full = x * y;       exp_res = full % 256; exp_c = (full > 255); end
                    default: begin exp_res = 255 - x; exp_c = 0; end
                endcase
                exp_rd = int'(rd); m_rs1 = int'(rs1); m_rs2 = int'(rs2);
                wb_cyc = cyc + ((op == 3'd6) ? 9 : 1);
                pending = 1;
                acc_cyc.push_back(cyc);
            end
            if (pre_en) mrf[pre_addr] = int'(pre_val);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_reg(input int a, input int v);
        pre_en = 1'b1; pre_addr = AW'(a); pre_val = DW'(v);
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic issue(input int o, input int d, input int s1, input int s2);
        bit got;
        got = 0;
        op = 3'(o); rd = AW'(d); rs1 = AW'(s1); rs2 = AW'(s2); in_valid = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        bit ok;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit ok;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        chk("reset_we", int'(we), 0);
        chk("reset_flags", int'({flag_z, flag_c}), 0);

        // ADD with carry
        set_reg(1, 200); set_reg(2, 100);
        issue(0, 3, 1, 2); wait_done();
        chk("add_r3", int'(rf[3]), 44);
        chk("add_c", int'(flag_c), 1);
        chk("add_z", int'(flag_z), 0);
        chk("add_lat", last_we_cyc - acc_cyc[$], 1);

        // SUB zero then borrow
        set_reg(1, 5); set_reg(2, 5);
        issue(1, 4, 1, 2); wait_done();
        chk("sub0_r4", int'(rf[4]), 0);
        chk("sub0_zc", int'({flag_z, flag_c}), 2);
        set_reg(1, 3);
        issue(1, 4, 1, 2); wait_done();
        chk("sub_r4", int'(rf[4]), 254);
        chk("sub_zc", int'({flag_z, flag_c}), 1);

        // MUL
        set_reg(1, 13); set_reg(2, 11);
        issue(6, 5, 1, 2); wait_done();
        chk("mul_r5", int'(rf[5]), 143);
        chk("mul_c", int'(flag_c), 0);
        chk("mul_lat", last_we_cyc - acc_cyc[$], 9);
        set_reg(1, 16); set_reg(2, 16);
        issue(6, 6, 1, 2); wait_done();
        chk("mul_ov_r6", int'(rf[6]), 0);
        chk("mul_ov_zc", int'({flag_z, flag_c}), 3);

        // dependent back-to-back, in_valid held
        set_reg(1, 3);
        n0 = acc_cyc.size();
        op = 3'd0; rd = 3'd1; rs1 = 3'd1; rs2 = 3'd1; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cyc.size() >= n0 + 2) ok = 1;
        end
        in_valid = 1'b0;
        if (!ok) chk("b2b_timeout", 0, 1);
        else chk("b2b_spacing", acc_cyc[n0 + 1] - acc_cyc[n0], 2);
        wait_done();
        chk("b2b_r1", int'(rf[1]), 12);

        // NOT / MOV with rd == rs1, then logic ops
        set_reg(2, 8'h0F);
        issue(7, 2, 2, 0); wait_done();
        chk("not_r2", int'(rf[2]), 8'hF0);
        chk("not_c", int'(flag_c), 0);
        issue(5, 7, 2, 0); wait_done();
        chk("mov_r7", int'(rf[7]), 8'hF0);
        set_reg(3, 8'h3C);
        issue(2, 0, 2, 3); wait_done();
        chk("and_r0", int'(rf[0]), 8'h30);
        issue(3, 0, 2, 3); wait_done();
        chk("or_r0", int'(rf[0]), 8'hFC);
        issue(4, 0, 2, 3); wait_done();
        chk("xor_r0", int'(rf[0]), 8'hCC);

        // leave carry set, then reset in the middle of a multiply
        set_reg(1, 200); set_reg(2, 100);
        issue(0, 6, 1, 2); wait_done();
        chk("pre_rst_c", int'(flag_c), 1);
        set_reg(1, 13); set_reg(2, 11);
        issue(6, 5, 1, 2);
        we_seen = 0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_flags", int'({flag_z, flag_c}), 0);
        chk("midrst_r1", int'(rf[1]), 0);
        chk("midrst_r5", int'(rf[5]), 0);
        @(posedge clk); #1 areset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_we", we_seen, 0);
        set_reg(1, 13); set_reg(2, 11);
        issue(6, 5, 1, 2); wait_done();
        chk("post_rst_r5", int'(rf[5]), 143);
        chk("post_rst_lat", last_we_cyc - acc_cyc[$], 9);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
